// File: rtl/divide_seq_if.sv
// Request/result bundle for the sequential divider.
// Handshake: the master raises start with stable operands; the divider takes them
// on the first rising edge it is idle (busy=0). out_valid pulses for one cycle with the result.
interface divide_seq_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             out_valid;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, out_valid, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, out_valid, div_by_zero
  );
endinterface

// File: rtl/divide_seq.sv
// Restoring unsigned divider producing one quotient bit per clock, MSB first.
// A zero divisor skips the iterations and reports all-ones quotient with the dividend as remainder.
module divide_seq #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  divide_seq_if.slave bus,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  always_comb begin
    trial    = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    // A set top bit would mean the shifted value already exceeds any WIDTH-bit divisor.
    ge       = rem_q[WIDTH] | (trial >= {1'b0, dvs_q});
    rem_next = ge ? (trial - {1'b0, dvs_q}) : trial;
    quo_next = {dvd_q[WIDTH-2:0], ge};

    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          dvd_d  = bus.dividend;
          dvs_d  = bus.divisor;
          rem_d  = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (bus.divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_next;
        dvd_d = quo_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d     = DONE;
          quotient_d  = quo_next;
          remainder_d = rem_next[WIDTH-1:0];
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_divide_seq.sv
// Directed and exhaustive checks of divide_seq at WIDTH=4: latency, results,
// divide-by-zero, start while busy, back-to-back starts and reset abort.
module tb_divide_seq;

  localparam int W = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_tests;
  int         n_fail;

  divide_seq_if #(.WIDTH(W)) dif ();

  divide_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (dif.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: issues one request from a falling edge and waits for out_valid (bounded).
  // Returns at the falling edge where out_valid is seen, or after the bound expires.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] q,
                        output logic [W-1:0] r, output logic dbz);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(negedge clk);
    dif.start = 1'b0;
    lat = 1;
    while (!dif.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q   = dif.quotient;
    r   = dif.remainder;
    dbz = dif.div_by_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dif.quotient !== 4'd0 || dif.remainder !== 4'd0 || dif.busy !== 1'b0 ||
        dif.out_valid !== 1'b0 || dif.div_by_zero !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async: q=%0d r=%0d busy=%0b ov=%0b dbz=%0b st=%0d, required all 0",
               dif.quotient, dif.remainder, dif.busy, dif.out_valid, dif.div_by_zero, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] a_v[3] = '{4'd13, 4'd2, 4'd15};
    logic [W-1:0] b_v[3] = '{4'd3, 4'd9, 4'd1};
    logic [W-1:0] q_v[3] = '{4'd4, 4'd0, 4'd15};
    logic [W-1:0] r_v[3] = '{4'd1, 4'd2, 4'd0};
    int lat;
    logic [W-1:0] q, r;
    logic dbz;
    for (int i = 0; i < 3; i++) begin
      do_div(a_v[i], b_v[i], lat, q, r, dbz);
      n_tests++;
      if (lat !== 5 || q !== q_v[i] || r !== r_v[i] || dbz !== 1'b0 || dif.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_%0d/%0d: lat=%0d q=%0d r=%0d dbz=%0b busy=%0b, required lat=5 q=%0d r=%0d dbz=0 busy=1",
                 a_v[i], b_v[i], lat, q, r, dbz, dif.busy, q_v[i], r_v[i]);
      end
      dif.dividend = 4'd0;
      dif.divisor  = 4'd5;
      @(negedge clk);
      n_tests++;
      if (dif.out_valid !== 1'b0 || dif.busy !== 1'b0 || dif.quotient !== q_v[i] ||
          dif.remainder !== r_v[i]) begin
        n_fail++;
        $display("FAIL basic_hold_%0d: ov=%0b busy=%0b q=%0d r=%0d, required ov=0 busy=0 q=%0d r=%0d",
                 i, dif.out_valid, dif.busy, dif.quotient, dif.remainder, q_v[i], r_v[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [W-1:0] q, r;
    logic dbz;
    do_div(4'd7, 4'd0, lat, q, r, dbz);
    n_tests++;
    if (lat !== 1 || q !== 4'd15 || r !== 4'd7 || dbz !== 1'b1) begin
      n_fail++;
      $display("FAIL div_zero: lat=%0d q=%0d r=%0d dbz=%0b, required lat=1 q=15 r=7 dbz=1",
               lat, q, r, dbz);
    end
    @(negedge clk);
    n_tests++;
    if (dif.out_valid !== 1'b0 || dif.busy !== 1'b0 || dif.div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL div_zero_after: ov=%0b busy=%0b dbz=%0b, required ov=0 busy=0 dbz=1",
               dif.out_valid, dif.busy, dif.div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    dif.start    = 1'b1;
    dif.dividend = 4'd13;
    dif.divisor  = 4'd3;
    @(negedge clk);
    dif.start = 1'b0;
    @(negedge clk);
    // new request held high while the first division is still iterating
    dif.start    = 1'b1;
    dif.dividend = 4'd9;
    dif.divisor  = 4'd2;
    lat = 2;
    while (!dif.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (lat !== 5 || dif.quotient !== 4'd4 || dif.remainder !== 4'd1 || dif.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d q=%0d r=%0d dbz=%0b, required lat=5 q=4 r=1 dbz=0",
               lat, dif.quotient, dif.remainder, dif.div_by_zero);
    end
    @(negedge clk);
    n_tests++;
    if (dif.busy !== 1'b0 || dif.out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: busy=%0b ov=%0b st=%0d, required busy=0 ov=0 st=0",
               dif.busy, dif.out_valid, dbg_state);
    end
    @(negedge clk);
    dif.start = 1'b0;
    n_tests++;
    if (dif.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_accept: busy=%0b, required 1", dif.busy);
    end
    lat = 1;
    while (!dif.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (lat !== 5 || dif.quotient !== 4'd4 || dif.remainder !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d q=%0d r=%0d, required lat=5 q=4 r=1",
               lat, dif.quotient, dif.remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int pulses;
    int lat;
    logic [W-1:0] q, r;
    logic dbz;
    dif.start    = 1'b1;
    dif.dividend = 4'd13;
    dif.divisor  = 4'd3;
    @(negedge clk);
    dif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dif.quotient !== 4'd0 || dif.remainder !== 4'd0 || dif.busy !== 1'b0 ||
        dif.out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL abort_reset: q=%0d r=%0d busy=%0b ov=%0b st=%0d, required all 0",
               dif.quotient, dif.remainder, dif.busy, dif.out_valid, dbg_state);
    end
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (dif.out_valid) pulses++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (dif.out_valid) pulses++;
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_no_pulse: out_valid pulses=%0d, required 0", pulses);
    end
    // request presented as reset releases: first edge must accept it
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_div(4'd13, 4'd3, lat, q, r, dbz);
    n_tests++;
    if (lat !== 5 || q !== 4'd4 || r !== 4'd1 || dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_fresh: lat=%0d q=%0d r=%0d dbz=%0b, required lat=5 q=4 r=1 dbz=0",
               lat, q, r, dbz);
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive();
    int order[256];
    int lat;
    int bad;
    int j;
    int tmp;
    logic [W-1:0] a, b, q, r;
    logic dbz;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      a = W'(order[i] / 16);
      b = W'(order[i] % 16);
      do_div(a, b, lat, q, r, dbz);
      n_tests++;
      if (b == 4'd0) begin
        if (lat !== 1 || q !== 4'd15 || r !== a || dbz !== 1'b1) begin
          n_fail++;
          bad++;
          if (bad <= 5)
            $display("FAIL exh_%0d/0: lat=%0d q=%0d r=%0d dbz=%0b, required lat=1 q=15 r=%0d dbz=1",
                     a, lat, q, r, dbz, a);
        end
      end else if (lat !== 5 || (int'(q) * int'(b) + int'(r)) != int'(a) || r >= b || dbz !== 1'b0) begin
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL exh_%0d/%0d: lat=%0d q=%0d r=%0d dbz=%0b, required lat=5 q=%0d r=%0d dbz=0",
                   a, b, lat, q, r, dbz, a / b, a % b);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    #2;
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/divide_seq.md
DIVIDE_SEQ -- requirements
Module: divide_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, operand and result bit width (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port: dividend  input  WIDTH  unsigned dividend; captured when start is accepted.
REQ-006 SHALL have port: divisor  input  WIDTH  unsigned divisor; captured when start is accepted.
REQ-007 SHALL have port: quotient  output  WIDTH  registered unsigned quotient.
REQ-008 SHALL have port: remainder  output  WIDTH  registered unsigned remainder.
REQ-009 SHALL have port: busy  output  1  high while the block is in CALC or DONE.
REQ-010 SHALL have port: out_valid  output  1  one-cycle pulse marking quotient/remainder/div_by_zero as valid.
REQ-011 SHALL have port: div_by_zero  output  1  high with a result produced from divisor == 0.

Function
REQ-012 SHALL implement three states: IDLE, CALC and DONE.
REQ-013 SHALL, in IDLE with start=1 at rising edge N, capture dividend and divisor, clear the partial remainder and the iteration counter, and enter CALC.
REQ-014 SHALL, when the captured divisor is 0 at edge N, bypass CALC and enter DONE directly.
REQ-015 SHALL perform one restoring iteration per clock in CALC, MSB first:
- shift the next dividend bit into the partial remainder;
- subtract the divisor when remainder >= divisor;
- shift the compare result into the quotient.
REQ-016 SHALL use a WIDTH+1-bit internal partial remainder so the compare never overflows.
REQ-017 SHALL complete exactly WIDTH iterations, at edges N+1..N+WIDTH, then enter DONE at edge N+WIDTH.
REQ-018 SHALL load quotient and remainder at the DONE entry edge.
REQ-019 SHALL drive out_valid=1 for exactly the one cycle spent in DONE.
REQ-020 SHALL, at the edge after DONE, return to IDLE and drive out_valid=0.
REQ-021 SHALL give a normal-division latency of WIDTH+1 cycles from the start-accept edge to the cycle with out_valid high.
REQ-022 SHALL give a divide-by-zero latency of 1 cycle from the start-accept edge to the cycle with out_valid high.
REQ-023 SHALL, for divisor == 0, set quotient to all ones, remainder to the dividend, and div_by_zero to 1.
REQ-024 SHALL, for a non-zero divisor, set div_by_zero to 0.
REQ-025 SHALL hold quotient, remainder and div_by_zero stable after DONE until the next result is loaded.
REQ-026 SHALL ignore start while busy=1: no restart, and in-flight operands are unaffected.
REQ-027 SHALL ignore changes on dividend and divisor after the start-accept edge.
REQ-028 SHALL keep busy=1 from the edge after start is accepted through the DONE cycle.
REQ-029 SHALL drive busy=0 in IDLE.
REQ-030 SHALL, when start is held high continuously, accept a new request at the first IDLE edge, giving back-to-back operations separated by one IDLE cycle.
REQ-031 SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor for every divisor != 0.

Reset
REQ-032 SHALL, while rst_n=0, force state=IDLE, quotient=0, remainder=0, busy=0, out_valid=0, div_by_zero=0, and clear the counter, immediately and independent of clk.
REQ-033 SHALL abort any operation in progress on rst_n assertion, with no out_valid pulse for the aborted operation.
REQ-034 SHALL accept start at the first rising edge after rst_n deasserts.

Verification
REQ-035 SHALL be verified with WIDTH=4: dividend=13, divisor=3, start for 1 cycle -> out_valid 5 cycles after the accept edge; quotient=4, remainder=1, div_by_zero=0.
REQ-036 SHALL be verified with: dividend=2, divisor=9 -> quotient=0, remainder=2; and dividend=15, divisor=1 -> quotient=15, remainder=0.
REQ-037 SHALL be verified with: dividend=7, divisor=0 -> out_valid 1 cycle after accept; quotient=15, remainder=7, div_by_zero=1.
REQ-038 SHALL be verified with: start=1 and new operands (9/2) applied during CALC of 13/3 -> result is still 4 r 1; 9/2 is accepted only after returning to IDLE, giving 4 r 1.
REQ-039 SHALL be verified with: rst_n pulsed low 2 cycles after accepting 13/3 -> outputs 0, no out_valid pulse; a fresh 13/3 afterwards gives 4 r 1.
REQ-040 SHALL be verified with an exhaustive random check of all 256 operand pairs, each result checked against REQ-023 and REQ-031.
